// File: rtl/stack_pkg.sv
// stack_pkg: shared opcodes, error codes, FSM/step encodings and defaults for the RPN sequencer.
// No ports; imported by the interface, the ALU and the sequencer top.
package stack_pkg;
   localparam int DEPTH_DEF   = 16;
   localparam int TIMEOUT_DEF = 15;
   typedef enum logic [2:0] {OP_NOP, OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_DUP} op_e;
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_OVF  = 2'd1;
   localparam logic [1:0] ERR_UNF  = 2'd2;
   localparam logic [1:0] ERR_TMO  = 2'd3;
   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_WAIT, S_ALU, S_RESP} state_e;
   typedef enum logic [1:0] {ST_PUSH, ST_POP, ST_ALU, ST_END} step_e;

   function automatic logic is_bin(op_e op);
      return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
   endfunction

   // Step s of each command's stack sequence; binary ops pop B then A, compute, push the result.
   function automatic step_e step_of(op_e op, logic [2:0] s);
      case (op)
         OP_PUSH: return s == 3'd0 ? ST_PUSH : ST_END;
         OP_POP:  return s == 3'd0 ? ST_POP : ST_END;
         OP_DUP:  return s == 3'd0 ? ST_POP : s < 3'd3 ? ST_PUSH : ST_END;
         default: return !is_bin(op) ? ST_END : s < 3'd2 ? ST_POP : s == 3'd2 ? ST_ALU :
                         s == 3'd3 ? ST_PUSH : ST_END;
      endcase
   endfunction
endpackage

// File: rtl/stack_rpn_sequencer_if.sv
// stack_rpn_sequencer_if: host command/result/error signals plus the stack request bus.
// slave  : sequencer side (takes cmd_*, stk_rdata, stk_done; drives the rest)
// master : host + stack side
interface stack_rpn_sequencer_if;
   import stack_pkg::*;
   logic       cmd_valid;
   logic       cmd_ready;
   op_e        cmd_op;
   logic [7:0] cmd_data;
   logic       res_valid;
   logic [7:0] res_data;
   logic       res_carry;
   logic       err_valid;
   logic [1:0] err_code;
   logic [4:0] depth;
   logic       stk_push;
   logic       stk_pop;
   logic [7:0] stk_wdata;
   logic [7:0] stk_rdata;
   logic       stk_done;
   modport slave (input cmd_valid, cmd_op, cmd_data, stk_rdata, stk_done,
                  output cmd_ready, res_valid, res_data, res_carry, err_valid, err_code,
                  depth, stk_push, stk_pop, stk_wdata);
   modport master (output cmd_valid, cmd_op, cmd_data, stk_rdata, stk_done,
                   input cmd_ready, res_valid, res_data, res_carry, err_valid, err_code,
                   depth, stk_push, stk_pop, stk_wdata);
endinterface

// File: rtl/stack_rpn_alu.sv
// stack_rpn_alu: combinational 8-bit ALU for the RPN sequencer.
// op: opcode; a, b: operands (a was below b on the stack); res: result mod 256;
// carry: ADD carry-out, SUB borrow (a<b), 0 for AND/OR.
module stack_rpn_alu
   import stack_pkg::*;
(
   input  op_e        op,
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] res,
   output logic       carry
);
   logic [8:0] sum, dif;
   assign sum = {1'b0, a} + {1'b0, b};
   // Bit 8 of the 9-bit difference is set exactly when a<b.
   assign dif = {1'b0, a} - {1'b0, b};
   always_comb begin
      {carry, res} = op == OP_ADD ? sum : op == OP_SUB ? dif :
                     op == OP_OR ? {1'b0, a | b} : {1'b0, a & b};
   end
endmodule

// File: rtl/stack_rpn_sequencer.sv
// stack_rpn_sequencer: turns host RPN commands into push/pop request sequences for a byte stack.
// clk, rst_n (async active-low); bus: stack_rpn_sequencer_if.slave carrying the host
// command handshake, result/error pulses, tracked depth and the stack push/pop bus.
module stack_rpn_sequencer
   import stack_pkg::*;
#(
   parameter int DEPTH   = DEPTH_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input logic                   clk,
   input logic                   rst_n,
   stack_rpn_sequencer_if.slave  bus
);
   localparam int TW = $clog2(TIMEOUT + 1);

   state_e        state, nxt;
   op_e           op;
   step_e         cur, nx;
   logic [2:0]    s;
   logic [7:0]    a, b, a_n, alu_res, wdata, res_data;
   logic          carry, alu_carry, res_carry, fin;
   logic [4:0]    depth_q;
   logic [TW-1:0] tcnt;

   stack_rpn_alu u_alu (.op(op), .a(a), .b(b), .res(alu_res), .carry(alu_carry));

   assign cur = step_of(op, s);
   assign nx  = step_of(op, s + 3'd1);
   // A is the working byte: immediate, popped value (except B of a binary op) or ALU result.
   assign a_n = state == S_ALU ? alu_res :
                (fin && cur == ST_POP && !(is_bin(op) && s == 3'd0)) ? bus.stk_rdata : a;

   assign bus.depth     = depth_q;
   assign bus.stk_wdata = wdata;
   assign bus.res_data  = res_data;
   assign bus.res_carry = res_carry;

   always_comb begin
      nxt           = state;
      fin           = 1'b0;
      bus.cmd_ready = 1'b0;
      bus.err_valid = 1'b0;
      bus.err_code  = ERR_NONE;
      bus.stk_push  = 1'b0;
      bus.stk_pop   = 1'b0;
      bus.res_valid = 1'b0;
      case (state)
         S_IDLE: begin
            bus.cmd_ready = 1'b1;
            nxt = bus.cmd_valid ? S_CHECK : S_IDLE;
         end
         S_CHECK: begin
            if ((op == OP_PUSH || op == OP_DUP) && depth_q == 5'(DEPTH)) begin
               bus.err_valid = 1'b1;
               bus.err_code  = ERR_OVF;
            end else if (((op == OP_POP || op == OP_DUP) && depth_q == 5'd0) ||
                         (is_bin(op) && depth_q < 5'd2)) begin
               bus.err_valid = 1'b1;
               bus.err_code  = ERR_UNF;
            end
            nxt = (bus.err_valid || op == OP_NOP) ? S_IDLE : S_REQ;
         end
         S_REQ: begin
            bus.stk_push = cur == ST_PUSH;
            bus.stk_pop  = cur == ST_POP;
            nxt = S_WAIT;
         end
         S_WAIT: begin
            // stk_done in the first WAIT cycle may be stale from the previous step.
            if (tcnt != '0 && bus.stk_done) begin
               fin = 1'b1;
               nxt = nx == ST_ALU ? S_ALU : nx == ST_END ? S_RESP : S_REQ;
            end else if (tcnt == TW'(TIMEOUT - 1)) begin
               bus.err_valid = 1'b1;
               bus.err_code  = ERR_TMO;
               nxt = S_IDLE;
            end
         end
         S_ALU: begin
            fin = 1'b1;
            nxt = S_REQ;
         end
         S_RESP: begin
            bus.res_valid = 1'b1;
            nxt = S_IDLE;
         end
         default: nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         op        <= OP_NOP;
         s         <= '0;
         a         <= '0;
         b         <= '0;
         carry     <= 1'b0;
         depth_q   <= '0;
         tcnt      <= '0;
         wdata     <= '0;
         res_data  <= '0;
         res_carry <= 1'b0;
      end else begin
         state <= nxt;
         a     <= a_n;
         if (state == S_IDLE && bus.cmd_valid) begin
            op    <= bus.cmd_op;
            a     <= bus.cmd_data;
            s     <= '0;
            carry <= 1'b0;
         end
         if (fin) s <= s + 3'd1;
         if (fin && cur == ST_POP && is_bin(op) && s == 3'd0) b <= bus.stk_rdata;
         if (fin && state == S_WAIT) depth_q <= cur == ST_PUSH ? depth_q + 5'd1 : depth_q - 5'd1;
         if (state == S_ALU) carry <= alu_carry;
         tcnt <= state == S_WAIT ? tcnt + TW'(1) : '0;
         if (nxt == S_REQ) wdata <= a_n;
         if (nxt == S_RESP) begin
            res_data  <= a_n;
            res_carry <= carry;
         end
      end
   end
endmodule

// File: tb/tb_stack_rpn_sequencer.sv
// tb_stack_rpn_sequencer: directed self-checking bench with a behavioural 16-byte stack model.
// No ports; drives clk/rst_n and the interface master side.
module tb_stack_rpn_sequencer;
   import stack_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   stack_rpn_sequencer_if bus();
   stack_rpn_sequencer #(.DEPTH(16), .TIMEOUT(15)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Stack model: completes each request with a one-cycle stk_done two edges after the request.
   logic [7:0] mem [16];
   int         sp = 0;
   int         cnt = 0;
   logic       hang = 1'b0;
   logic       pend_pop = 1'b0;
   logic [7:0] pend_w = '0;

   always @(posedge clk) begin
      #1;
      bus.stk_done = 1'b0;
      if (!rst_n) begin
         sp  = 0;
         cnt = 0;
      end else begin
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0 && !hang) begin
               bus.stk_done = 1'b1;
               if (pend_pop) begin
                  sp--;
                  bus.stk_rdata = mem[sp];
               end else begin
                  check("wdata_hold", bus.stk_wdata, pend_w);
                  mem[sp] = pend_w;
                  sp++;
               end
            end
         end
         if (bus.stk_push || bus.stk_pop) begin
            cnt      = 2;
            pend_pop = bus.stk_pop;
            pend_w   = bus.stk_wdata;
         end
      end
   end

   int         kind, lat, rdy, n_push, n_pop;
   logic [7:0] rdat, w_first, w_last;
   logic       rcar;
   logic [1:0] rcode;

   // Issue one command, then watch until the sequencer is idle again. Cycle 1 = first after accept.
   task automatic run(input op_e op, input logic [7:0] d);
      int  cyc;
      bit  fin;
      kind = 0; lat = 0; rdy = 0; n_push = 0; n_pop = 0;
      rdat = 'x; rcar = 'x; rcode = 'x; w_first = 'x; w_last = 'x;
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_data  = d;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      cyc = 0;
      fin = 0;
      while (!fin && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (bus.stk_push) begin
            n_push++;
            w_last = bus.stk_wdata;
            if (n_push == 1) w_first = bus.stk_wdata;
         end
         if (bus.stk_pop) n_pop++;
         if (bus.res_valid) begin kind = 1; rdat = bus.res_data; rcar = bus.res_carry; lat = cyc; end
         if (bus.err_valid) begin kind = 2; rcode = bus.err_code; lat = cyc; end
         if (bus.cmd_ready) begin fin = 1; rdy = cyc; end
      end
      check("back_to_idle", 32'(fin), 32'd1);
   endtask

   task automatic expect_res(input string tag, input logic [7:0] v, input logic c, input int dep);
      check({tag, "_kind"}, kind, 1);
      check({tag, "_data"}, rdat, v);
      check({tag, "_carry"}, rcar, c);
      check({tag, "_depth"}, bus.depth, dep);
   endtask

   task automatic expect_err(input string tag, input logic [1:0] code, input int dep);
      check({tag, "_kind"}, kind, 2);
      check({tag, "_code"}, rcode, code);
      check({tag, "_depth"}, bus.depth, dep);
   endtask

   initial begin
      int n;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = OP_NOP;
      bus.cmd_data  = '0;
      bus.stk_done  = 1'b0;
      bus.stk_rdata = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", bus.cmd_ready, 1);
      check("rst_depth", bus.depth, 0);
      check("rst_pulses", {bus.res_valid, bus.err_valid, bus.stk_push, bus.stk_pop}, 0);
      rst_n = 1'b1;

      run(OP_PUSH, 8'h05);
      expect_res("push05", 8'h05, 1'b0, 1);
      check("push05_wdata", w_last, 8'h05);
      check("push05_npush", n_push, 1);
      check("push05_latency", lat, 5);
      run(OP_PUSH, 8'h07);
      expect_res("push07", 8'h07, 1'b0, 2);
      check("push07_wdata", w_last, 8'h07);

      run(OP_ADD, 8'h00);
      expect_res("add_5_7", 8'h0C, 1'b0, 1);
      check("add_pops", n_pop, 2);
      check("add_pushes", n_push, 1);
      check("add_wdata", w_last, 8'h0C);

      run(OP_PUSH, 8'hF0);
      run(OP_PUSH, 8'h20);
      run(OP_ADD, 8'h00);
      expect_res("add_carry", 8'h10, 1'b1, 2);

      run(OP_PUSH, 8'h03);
      run(OP_PUSH, 8'h05);
      run(OP_SUB, 8'h00);
      expect_res("sub_borrow", 8'hFE, 1'b1, 3);

      run(OP_PUSH, 8'h3C);
      run(OP_AND, 8'h00);
      expect_res("and", 8'h3C, 1'b0, 3);
      run(OP_OR, 8'h00);
      expect_res("or", 8'h3C, 1'b0, 2);
      run(OP_POP, 8'h00);
      expect_res("pop", 8'h3C, 1'b0, 1);
      check("pop_npop", n_pop, 1);
      check("pop_latency", lat, 5);

      run(OP_ADD, 8'h00);
      expect_err("add_underflow", ERR_UNF, 1);
      check("add_underflow_access", n_push + n_pop, 0);
      check("add_underflow_latency", lat, 1);

      run(OP_DUP, 8'h00);
      expect_res("dup", 8'h0C, 1'b0, 2);
      check("dup_npop", n_pop, 1);
      check("dup_npush", n_push, 2);
      check("dup_w_first", w_first, 8'h0C);
      check("dup_w_last", w_last, 8'h0C);
      run(OP_POP, 8'h00);
      expect_res("pop_dup1", 8'h0C, 1'b0, 1);
      run(OP_POP, 8'h00);
      expect_res("pop_dup2", 8'h0C, 1'b0, 0);
      run(OP_POP, 8'h00);
      expect_err("pop_empty", ERR_UNF, 0);
      run(OP_DUP, 8'h00);
      expect_err("dup_empty", ERR_UNF, 0);
      run(OP_NOP, 8'h00);
      check("nop_kind", kind, 0);
      check("nop_access", n_push + n_pop, 0);
      check("nop_ready", rdy, 2);

      for (int i = 0; i < 16; i++) run(OP_PUSH, 8'(i));
      check("fill_depth", bus.depth, 16);
      run(OP_PUSH, 8'hAA);
      expect_err("push_full", ERR_OVF, 16);
      check("push_full_access", n_push + n_pop, 0);
      run(OP_DUP, 8'h00);
      expect_err("dup_full", ERR_OVF, 16);

      hang = 1'b1;
      run(OP_POP, 8'h00);
      expect_err("timeout", ERR_TMO, 16);
      check("timeout_cycle", lat, 17);
      check("timeout_ready", rdy, 18);
      check("timeout_npop", n_pop, 1);
      hang = 1'b0;

      run(OP_POP, 8'h00);
      expect_res("pop_after_timeout", 8'h0F, 1'b0, 15);

      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = OP_DUP;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      n = 0;
      while (n < 20 && !bus.stk_push) begin
         @(negedge clk);
         n++;
      end
      check("dup_first_push_seen", 32'(n < 20), 1);
      #3 rst_n = 1'b0;
      #1;
      check("arst_ready", bus.cmd_ready, 1);
      check("arst_depth", bus.depth, 0);
      check("arst_pulses", {bus.res_valid, bus.err_valid, bus.stk_push, bus.stk_pop}, 0);
      check("arst_res_data", bus.res_data, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(OP_PUSH, 8'hA5);
      expect_res("push_after_rst", 8'hA5, 1'b0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
